// File: rtl/alu_seq_muldiv_if.sv
// alu_seq_muldiv_if: request/result bundle (start, operands, ALUctrl -> ALUout, EQ, valid, busy)
interface alu_seq_muldiv_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [DATA_WIDTH-1:0] ALUop1;
  logic                  ALUsrc;
  logic [DATA_WIDTH-1:0] regOp2;
  logic [DATA_WIDTH-1:0] ImmOp;
  logic [3:0]            ALUctrl;
  logic [DATA_WIDTH-1:0] ALUout;
  logic                  EQ;
  logic                  valid;
  logic                  busy;
  modport master (output start, ALUop1, ALUsrc, regOp2, ImmOp, ALUctrl, input ALUout, EQ, valid, busy);
  modport slave  (input start, ALUop1, ALUsrc, regOp2, ImmOp, ALUctrl, output ALUout, EQ, valid, busy);
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle ALU, clk/rst plus bus (start/operands/ALUctrl in; ALUout/EQ/valid/busy out)
module alu_seq_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic           clk,
  input logic           rst,
  alu_seq_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, CALC} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       iop_q, iop_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, out_q, out_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic             eq_q, eq_d, valid_q, valid_d;
  logic [W-1:0]     op2, res;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic             accept, is_iter;
  logic [W:0]       msum, dsh, ddiff;
  logic [2*W-1:0]   mul_nx, div_nx, step;
  assign op2     = bus.ALUsrc ? bus.ImmOp : bus.regOp2;
  assign shamt   = op2[SHAMT_WIDTH-1:0];
  assign accept  = bus.start && state_q == IDLE;
  assign is_iter = bus.ALUctrl inside {4'd10, 4'd11, 4'd12, 4'd13};
  always_comb begin
    res = '0;
    case (bus.ALUctrl)
      4'd0: res = bus.ALUop1 + op2;
      4'd1: res = bus.ALUop1 - op2;
      4'd2: res = bus.ALUop1 & op2;
      4'd3: res = bus.ALUop1 | op2;
      4'd4: res = bus.ALUop1 ^ op2;
      4'd5: res = {{(W-1){1'b0}}, $signed(bus.ALUop1) < $signed(op2)};
      4'd6: res = {{(W-1){1'b0}}, bus.ALUop1 < op2};
      4'd7: res = bus.ALUop1 << shamt;
      4'd8: res = bus.ALUop1 >> shamt;
      4'd9: res = $unsigned($signed(bus.ALUop1) >>> shamt);
      default: res = '0;
    endcase
  end
  // shift-add: acc = {partial high, remaining multiplier}; restoring divide: acc = {remainder, dividend/quotient}
  assign msum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nx = {msum, acc_q[W-1:1]};
  assign dsh    = {acc_q[2*W-1:W], acc_q[W-1]};
  assign ddiff  = dsh - {1'b0, b_q};
  assign div_nx = {ddiff[W] ? dsh[W-1:0] : ddiff[W-1:0], acc_q[W-2:0], !ddiff[W]};
  assign step   = iop_q[1] ? div_nx : mul_nx;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iop_d   = iop_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    eq_d    = eq_q;
    valid_d = 1'b0;
    if (state_q == CALC) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        out_d   = iop_q[0] ? step[2*W-1:W] : step[W-1:0];
        eq_d    = a_q == b_q;
      end
    end else if (accept) begin
      a_d   = bus.ALUop1;
      b_d   = op2;
      iop_d = {bus.ALUctrl[2], bus.ALUctrl[0]};
      if (is_iter) begin
        state_d = CALC;
        cnt_d   = '0;
        acc_d   = {{W{1'b0}}, bus.ALUctrl[2] ? bus.ALUop1 : op2};
      end else begin
        valid_d = 1'b1;
        out_d   = res;
        eq_d    = bus.ALUop1 == op2;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iop_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iop_q   <= iop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      eq_q    <= eq_d;
      valid_q <= valid_d;
    end
  end
  assign bus.ALUout = out_q;
  assign bus.EQ     = eq_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = state_q == CALC;
endmodule
